mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM that sequences the multicycle MIPS datapath: PC/IR load, register file, ALU operand muxes, PC source and memory access.
- Adds a memory-ready handshake so fetch and data accesses stall on slow memory.
- Adds a retired-instruction counter and a state readout for debug.
- Sits beside the datapath. Consumes op, funct and zero; drives every datapath control input plus memory read/write strobes.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- op  input  6  instr[31:26] from datapath
- funct  input  6  instr[5:0] from datapath
- zero  input  1  ALU zero flag, same cycle
- memready  input  1  memory completes current read/write this cycle
- pcen  output  1  PC register enable
- irwrite  output  1  IR load enable
- regwrite  output  1  register file write enable
- alusrca  output  1  0=PC, 1=A
- iord  output  1  0=PC address, 1=ALUOut address
- memtoreg  output  1  0=ALUOut, 1=Data
- regdst  output  1  0=rt, 1=rd
- alusrcb  output  2  00=B, 01=4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  output  4  ALU operation
- memread  output  1  memory read strobe
- memwrite  output  1  memory write strobe
- state  output  4  current state encoding, debug
- instret  output  CNT_W  retired-instruction count

Behaviour:
- State register and counter reset asynchronously while reset=0: state=FETCH, instret=0.
- While reset=0, pcen, irwrite, regwrite, memread and memwrite are forced 0. All other outputs take their FETCH values.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, BNEEX=9, ADDIEX=10, ADDIWB=11, JEX=12. Codes 13-15 go to FETCH with no strobes.
- Outputs are combinational from state. The only exceptions are pcen, which also uses zero, and the memready-gated strobes.
- Unlisted outputs default to 0. alucontrol defaults to 0010 (add).
- ALU encoding: add=0010, sub=0110, and=0000, or=0001, slt=0111.
- pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero).
- FETCH: memread=1, alusrcb=01. irwrite and pcwrite are asserted only when memready=1.
  - memready=1: next state DECODE.
  - memready=0: hold FETCH with no PC/IR update.
- DECODE: alusrcb=11 (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw): MEMADR
  - 000000 (R-type) with funct in {100000, 100010, 100100, 100101, 101010}: RTYPEEX
  - 000100: BEQEX
  - 000101: BNEEX
  - 001000: ADDIEX
  - 000010: JEX
  - anything else: FETCH. The instruction is treated as a NOP and is not counted.
- MEMADR: alusrca=1, alusrcb=10. Next MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, memread=1. Hold until memready=1, then MEMWB.
- MEMWB: memtoreg=1, regdst=0, regwrite=1. Next FETCH.
- MEMWR: iord=1, memwrite=1. Hold until memready=1, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (add/sub/and/or/slt). Next RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BEQEX and BNEEX: alusrca=1, alusrcb=00, alucontrol=0110, pcsrc=01. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Next ADDIWB.
- ADDIWB: regdst=0, regwrite=1. Next FETCH.
- JEX: pcsrc=10, pcwrite=1. Next FETCH.
- Retire counter: instret increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, ADDIWB or JEX. It wraps modulo 2^CNT_W.
- Cycle counts at memready=1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each memready-low cycle adds one cycle in FETCH, MEMRD or MEMWR.
- Reset asserted mid-instruction: immediate return to FETCH and all strobes low. A partially executed instruction is not counted.

Test Plan:
- Reset held low, memready=1 -> state=0, pcen=irwrite=regwrite=memwrite=memread=0, instret=0. Release reset -> FETCH asserts pcen=1, irwrite=1, alusrcb=01.
- R-type add (op=000000, funct=100000), memready=1 -> states 0,1,6,7,0. RTYPEEX has alucontrol=0010. RTYPEWB has regdst=1, regwrite=1. instret=1.
- lw (op=100011) with memready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0 (8 cycles). MEMWB has memtoreg=1, regwrite=1.
- beq with zero=1 -> BEQEX pcen=1, pcsrc=01. Same with zero=0 -> pcen=0. bne is the inverse.
- j (op=000010) -> JEX has pcen=1, pcsrc=10. Illegal op=111111 -> DECODE then FETCH, instret unchanged.
- sw with memready=0 in FETCH for 3 cycles -> irwrite stays 0 until memready=1. Reset pulse while in MEMWR -> state=0, memwrite=0 immediately (asynchronous).

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. It adds a memory-ready stall
// handshake, a retired-instruction counter and a debug readout of the current state.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memready,
    output logic             pcen,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [3:0]       alucontrol,
    output logic             memread,
    output logic             memwrite,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
        BEQEX   = 4'd8,  BNEEX   = 4'd9,  ADDIEX  = 4'd10, ADDIWB  = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Returns {supported, alu_op}; unsupported functs decode as NOPs.
    function automatic logic [4:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: rtype_alu = {1'b1, 4'b0010};
            6'b100010: rtype_alu = {1'b1, 4'b0110};
            6'b100100: rtype_alu = {1'b1, 4'b0000};
            6'b100101: rtype_alu = {1'b1, 4'b0001};
            6'b101010: rtype_alu = {1'b1, 4'b0111};
            default:   rtype_alu = {1'b0, 4'b0010};
        endcase
    endfunction

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] instret_r;
    logic             pcwrite_s, irwrite_s, regwrite_s, memread_s, memwrite_s;
    logic             branch_eq_s, branch_ne_s, retire_s;
    logic [4:0]       rtype_s;

    assign rtype_s = rtype_alu(funct);

    // State register; reset drops any partially executed instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        next_state_s = FETCH;
        pcwrite_s    = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        memread_s    = 1'b0;
        memwrite_s   = 1'b0;
        branch_eq_s  = 1'b0;
        branch_ne_s  = 1'b0;
        retire_s     = 1'b0;
        alusrca      = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = 4'b0010;
        case (state_r)
            FETCH: begin
                memread_s = 1'b1;
                alusrcb   = 2'b01;
                if (memready) begin
                    irwrite_s    = 1'b1;
                    pcwrite_s    = 1'b1;
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = rtype_s[4] ? RTYPEEX : FETCH;
                    OP_BEQ:       next_state_s = BEQEX;
                    OP_BNE:       next_state_s = BNEEX;
                    OP_ADDI:      next_state_s = ADDIEX;
                    OP_J:         next_state_s = JEX;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                next_state_s = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord         = 1'b1;
                memread_s    = 1'b1;
                next_state_s = memready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                if (memready) begin
                    retire_s     = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            RTYPEEX: begin
                alusrca      = 1'b1;
                alucontrol   = rtype_s[3:0];
                next_state_s = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca     = 1'b1;
                alucontrol  = 4'b0110;
                pcsrc       = 2'b01;
                branch_eq_s = (state_r == BEQEX);
                branch_ne_s = (state_r == BNEEX);
                retire_s    = 1'b1;
            end
            ADDIEX: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                next_state_s = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
            end
            JEX: begin
                pcsrc     = 2'b10;
                pcwrite_s = 1'b1;
                retire_s  = 1'b1;
            end
            default: next_state_s = FETCH;
        endcase
    end

    // Strobes are held low for as long as reset is asserted.
    assign pcen     = reset & (pcwrite_s | (branch_eq_s & zero) | (branch_ne_s & ~zero));
    assign irwrite  = reset & irwrite_s;
    assign regwrite = reset & regwrite_s;
    assign memread  = reset & memread_s;
    assign memwrite = reset & memwrite_s;
    assign state    = state_r;
    assign instret  = instret_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed instruction sequences push the
// expected state/control/count per cycle, and a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        memready = 1'b1;
    logic        pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, memread, memwrite;
    logic [1:0]  alusrcb, pcsrc;
    logic [3:0]  alucontrol, state;
    logic [31:0] instret;

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .memread(memread), .memwrite(memwrite),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // Control vector: pcen irwrite regwrite memread memwrite | alusrca iord memtoreg regdst | alusrcb | pcsrc | alucontrol
    localparam logic [16:0] C_RESET      = 17'b00000_0000_01_00_0010;
    localparam logic [16:0] C_FETCH_RDY  = 17'b11010_0000_01_00_0010;
    localparam logic [16:0] C_FETCH_WAIT = 17'b00010_0000_01_00_0010;
    localparam logic [16:0] C_DECODE     = 17'b00000_0000_11_00_0010;
    localparam logic [16:0] C_MEMADR     = 17'b00000_1000_10_00_0010;
    localparam logic [16:0] C_MEMRD      = 17'b00010_0100_00_00_0010;
    localparam logic [16:0] C_MEMWB      = 17'b00100_0010_00_00_0010;
    localparam logic [16:0] C_MEMWR      = 17'b00001_0100_00_00_0010;
    localparam logic [16:0] C_RTWB       = 17'b00100_0001_00_00_0010;
    localparam logic [16:0] C_ADDIEX     = 17'b00000_1000_10_00_0010;
    localparam logic [16:0] C_ADDIWB     = 17'b00100_0000_00_00_0010;
    localparam logic [16:0] C_JEX        = 17'b10000_0000_00_10_0010;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_inst = 32'd0;
    logic [16:0] ctl_s;

    assign ctl_s = {pcen, irwrite, regwrite, memread, memwrite, alusrca, iord, memtoreg,
                    regdst, alusrcb, pcsrc, alucontrol};

    // Monitor: compare one expectation per cycle, mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (state !== mon_e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d", mon_e.tag, state, mon_e.st);
            end
            n_checks++;
            if (ctl_s !== mon_e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl (state %0d): got %b expected %b", mon_e.tag, state, ctl_s, mon_e.ctl);
            end
            n_checks++;
            if (instret !== mon_e.inst) begin
                n_fail++;
                $display("FAIL %s instret: got %0d expected %0d", mon_e.tag, instret, mon_e.inst);
            end
        end
    end

    task automatic step(input string t, input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic mr, input logic [3:0] es, input logic [16:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; op = o; funct = f; zero = z; memready = mr;
        e.tag = t; e.st = es; e.ctl = ec; e.inst = exp_inst;
        sb_q.push_back(e);
    endtask

    task automatic fetch_decode(input string t, input logic [5:0] o, input logic [5:0] f, input int waits);
        for (int i = 0; i < waits; i++) step(t, 1'b1, o, f, 1'b0, 1'b0, 4'd0, C_FETCH_WAIT);
        step(t, 1'b1, o, f, 1'b0, 1'b1, 4'd0, C_FETCH_RDY);
        step(t, 1'b1, o, f, 1'b0, 1'b1, 4'd1, C_DECODE);
    endtask

    task automatic rtype(input string t, input logic [5:0] f, input logic [3:0] alu);
        fetch_decode(t, 6'b000000, f, 0);
        step(t, 1'b1, 6'b000000, f, 1'b0, 1'b1, 4'd6, {13'b00000_1000_00_00, alu});
        step(t, 1'b1, 6'b000000, f, 1'b0, 1'b1, 4'd7, C_RTWB);
        exp_inst++;
    endtask

    task automatic lw(input string t, input int waits);
        fetch_decode(t, 6'b100011, 6'd0, 0);
        step(t, 1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, 4'd2, C_MEMADR);
        for (int i = 0; i < waits; i++) step(t, 1'b1, 6'b100011, 6'd0, 1'b0, 1'b0, 4'd3, C_MEMRD);
        step(t, 1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, 4'd3, C_MEMRD);
        step(t, 1'b1, 6'b100011, 6'd0, 1'b0, 1'b1, 4'd4, C_MEMWB);
        exp_inst++;
    endtask

    task automatic sw(input string t, input int fwaits, input int mwaits);
        fetch_decode(t, 6'b101011, 6'd0, fwaits);
        step(t, 1'b1, 6'b101011, 6'd0, 1'b0, 1'b1, 4'd2, C_MEMADR);
        for (int i = 0; i < mwaits; i++) step(t, 1'b1, 6'b101011, 6'd0, 1'b0, 1'b0, 4'd5, C_MEMWR);
        step(t, 1'b1, 6'b101011, 6'd0, 1'b0, 1'b1, 4'd5, C_MEMWR);
        exp_inst++;
    endtask

    task automatic branch(input string t, input logic [5:0] o, input logic z,
                          input logic [3:0] es, input logic exp_pcen);
        fetch_decode(t, o, 6'd0, 0);
        step(t, 1'b1, o, 6'd0, z, 1'b1, es, {exp_pcen, 16'b0000_1000_00_01_0110});
        exp_inst++;
    endtask

    task automatic jump(input string t);
        fetch_decode(t, 6'b000010, 6'd0, 0);
        step(t, 1'b1, 6'b000010, 6'd0, 1'b0, 1'b1, 4'd12, C_JEX);
        exp_inst++;
    endtask

    task automatic addi(input string t);
        fetch_decode(t, 6'b001000, 6'd0, 0);
        step(t, 1'b1, 6'b001000, 6'd0, 1'b0, 1'b1, 4'd10, C_ADDIEX);
        step(t, 1'b1, 6'b001000, 6'd0, 1'b0, 1'b1, 4'd11, C_ADDIWB);
        exp_inst++;
    endtask

    initial begin
        reset = 1'b0;
        step("reset0", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 4'd0, C_RESET);
        step("reset1", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 4'd0, C_RESET);
        rtype("add", 6'b100000, 4'b0010);
        rtype("sub", 6'b100010, 4'b0110);
        rtype("and", 6'b100100, 4'b0000);
        rtype("or",  6'b100101, 4'b0001);
        rtype("slt", 6'b101010, 4'b0111);
        lw("lw_wait2", 2);
        branch("beq_z1", 6'b000100, 1'b1, 4'd8, 1'b1);
        branch("beq_z0", 6'b000100, 1'b0, 4'd8, 1'b0);
        branch("bne_z0", 6'b000101, 1'b0, 4'd9, 1'b1);
        branch("bne_z1", 6'b000101, 1'b1, 4'd9, 1'b0);
        jump("j");
        fetch_decode("illegal_op", 6'b111111, 6'd0, 0);
        fetch_decode("illegal_funct", 6'b000000, 6'b001000, 0);
        addi("addi");
        sw("sw_fwait3", 3, 1);
        lw("lw_nowait", 0);
        // Store interrupted by reset while waiting on memory: not counted, counter cleared.
        fetch_decode("sw_rst", 6'b101011, 6'd0, 0);
        step("sw_rst", 1'b1, 6'b101011, 6'd0, 1'b0, 1'b1, 4'd2, C_MEMADR);
        step("sw_rst", 1'b1, 6'b101011, 6'd0, 1'b0, 1'b0, 4'd5, C_MEMWR);
        exp_inst = 32'd0;
        step("sw_rst_async", 1'b0, 6'b101011, 6'd0, 1'b0, 1'b0, 4'd0, C_RESET);
        jump("j_after_rst");
        step("final", 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 4'd0, C_FETCH_WAIT);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
